// File: rtl/uart_transmitter.sv
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter with a DEPTH-entry TX FIFO, timed by a
//               16x-baud clk_en tick. Define UART_TX_PARITY_EN for 8E1 frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_transmitter #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       wr_en,
  input  logic [7:0] data_in,
  output logic       full,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  state_t           r_state;
  logic [7:0]       r_shift;
  logic [3:0]       r_tick;
  logic [2:0]       r_bit_idx;
  logic             r_tx;
  logic             r_busy;
  logic             r_tx_done;
`ifdef UART_TX_PARITY_EN
  logic             r_parity;
`endif

  logic       w_empty;
  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_last_tick;
  logic [7:0] w_head;

  // Full/empty come from the pre-cycle count, so a same-cycle write is never
  // visible to the pop decision.
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_push      = wr_en && !w_full;
  assign w_last_tick = clk_en && (r_tick == 4'hF);
  assign w_pop       = clk_en && !w_empty &&
                       ((r_state == IDLE) || ((r_state == STOP) && (r_tick == 4'hF)));
  assign w_head      = r_mem[r_rd_ptr];

  assign full    = w_full;
  assign tx      = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_tx_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_tx_done <= 1'b0;
      if (clk_en) begin
        // The 4-bit tick counter wraps 15 -> 0 exactly when a bit ends.
        if (r_state != IDLE) r_tick <= r_tick + 4'd1;
        case (r_state)
          IDLE: begin
            if (w_pop) begin
              r_shift   <= w_head;
              r_tick    <= '0;
              r_bit_idx <= '0;
              r_tx      <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= START;
`ifdef UART_TX_PARITY_EN
              r_parity  <= ^w_head;
`endif
            end
          end
          START: begin
            if (w_last_tick) begin
              r_tx    <= r_shift[0];
              r_state <= DATA;
            end
          end
          DATA: begin
            if (w_last_tick) begin
              if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                r_tx    <= r_parity;
                r_state <= PARITY;
`else
                r_tx    <= 1'b1;
                r_state <= STOP;
`endif
              end else begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {1'b0, r_shift[7:1]};
                r_tx      <= r_shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            if (w_last_tick) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end
          end
`endif
          STOP: begin
            if (w_last_tick) begin
              r_tx_done <= 1'b1;
              // Back-to-back frames: load the next byte with no idle gap.
              if (w_pop) begin
                r_shift   <= w_head;
                r_tick    <= '0;
                r_bit_idx <= '0;
                r_tx      <= 1'b0;
                r_state   <= START;
`ifdef UART_TX_PARITY_EN
                r_parity  <= ^w_head;
`endif
              end else begin
                r_tx    <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end
          default: begin
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Directed self-checking bench for uart_transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_transmitter;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       wr_en;
  logic [7:0] data_in;
  logic       full;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int checks   = 0;
  int errors   = 0;
  int en_div   = 0;
  int en_ph    = 0;
  int done_cnt = 0;
  int d0;

  always #5 clk = ~clk;

  uart_transmitter #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .wr_en   (wr_en),
    .data_in (data_in),
    .full    (full),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  // clk_en generator: one-cycle tick every en_div clocks (0 = off)
  initial begin
    clk_en = 1'b0;
    forever begin
      @(negedge clk);
      if (en_div == 0) begin
        clk_en = 1'b0;
        en_ph  = 0;
      end else begin
        clk_en = (en_ph == 0);
        en_ph  = (en_ph + 1) % en_div;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (tx_done === 1'b1) done_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    data_in = b;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FRAME == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_start"}, {31'd0, tx}, 32'd0);
  endtask

  // Checks one frame from its start bit; optionally writes inj_b in the cycle
  // of the final stop tick. Returns on the negedge where tx_done is seen.
  task automatic check_frame(input logic [7:0] b, input int bitlen,
                             input logic inj, input logic [7:0] inj_b);
    int    total;
    int    k;
    int    r;
    string tag;
    total = FRAME * bitlen;
    tag   = $sformatf("frame_%02h", b);
    wait_start(tag);
    for (int n = 0; n <= total; n++) begin
      if (n < total) begin
        k = n / bitlen;
        r = n % bitlen;
        if (r == 0 || r == bitlen / 2 || r == bitlen - 1)
          check($sformatf("%s_bit%0d_t%0d", tag, k, r), {31'd0, tx}, {31'd0, exp_bit(b, k)});
      end
      if (n == total - 1) begin
        check({tag, "_done_early"}, {31'd0, tx_done}, 32'd0);
        if (inj) begin
          wr_en   = 1'b1;
          data_in = inj_b;
        end
      end
      if (n == total) begin
        check({tag, "_done"}, {31'd0, tx_done}, 32'd1);
        wr_en = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx",      {31'd0, tx},      32'd1);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_full",    {31'd0, full},    32'd0);
    check("rst_tx_done", {31'd0, tx_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 0x55 frame, tick every cycle
    en_div = 1;
    @(negedge clk);
    write_byte(8'h55);
    check_frame(8'h55, 16, 1'b0, 8'h00);
    check("idle_busy_55", {31'd0, busy}, 32'd0);
    check("idle_tx_55",   {31'd0, tx},   32'd1);

    // Fill FIFO with ticks stopped, drop a write while full
    en_div = 0;
    repeat (2) @(negedge clk);
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    check("full_after_3", {31'd0, full}, 32'd0);
    write_byte(8'h04);
    check("full_after_4", {31'd0, full}, 32'd1);
    write_byte(8'hFF);
    check("full_after_ff", {31'd0, full}, 32'd1);
    check("no_tick_busy",  {31'd0, busy}, 32'd0);
    check("no_tick_tx",    {31'd0, tx},   32'd1);
    d0     = done_cnt;
    en_div = 1;
    for (int i = 0; i < 4; i++) begin
      check_frame(8'(i + 1), 16, 1'b0, 8'h00);
      if (i < 3) check($sformatf("no_gap_%0d", i), {31'd0, tx}, 32'd0);
    end
    repeat (300) @(negedge clk);
    check("burst_done_count", done_cnt - d0, 32'd4);
    check("burst_no_ff_busy", {31'd0, busy}, 32'd0);
    check("burst_no_ff_tx",   {31'd0, tx},   32'd1);

    // Write coincident with final stop tick: while full, then while not full
    write_byte(8'h11);
    fork
      check_frame(8'h11, 16, 1'b1, 8'hEE);
      begin
        repeat (8) @(negedge clk);
        write_byte(8'h21);
        write_byte(8'h22);
        write_byte(8'h23);
        write_byte(8'h24);
        check("refill_full", {31'd0, full}, 32'd1);
      end
    join
    check("drop_at_stop_full", {31'd0, full}, 32'd0);
    check_frame(8'h21, 16, 1'b1, 8'h5A);
    check("pushpop_full", {31'd0, full}, 32'd0);
    fork
      check_frame(8'h22, 16, 1'b0, 8'h00);
      begin
        write_byte(8'h6B);
        check("count_kept_full", {31'd0, full}, 32'd1);
      end
    join
    check_frame(8'h23, 16, 1'b0, 8'h00);
    check_frame(8'h24, 16, 1'b0, 8'h00);
    check_frame(8'h5A, 16, 1'b0, 8'h00);
    check_frame(8'h6B, 16, 1'b0, 8'h00);
    check("stop_seq_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of data bit 3 of 0xA5, with 0x99 queued behind it
    write_byte(8'hA5);
    write_byte(8'h99);
    wait_start("rst_a5");
    repeat (4 * 16 + 8) @(negedge clk);
    check("a5_bit3", {31'd0, tx},   32'd0);
    check("a5_busy", {31'd0, busy}, 32'd1);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check("midrst_tx",      {31'd0, tx},      32'd1);
    check("midrst_busy",    {31'd0, busy},    32'd0);
    check("midrst_tx_done", {31'd0, tx_done}, 32'd0);
    check("midrst_full",    {31'd0, full},    32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("midrst_no_done",  done_cnt - d0,   32'd0);
    check("midrst_discard",  {31'd0, busy},   32'd0);
    write_byte(8'h3C);
    check_frame(8'h3C, 16, 1'b0, 8'h00);

    // Tick every 3rd clock: 48-clock bits
    en_div = 3;
    repeat (3) @(negedge clk);
    write_byte(8'h80);
    check_frame(8'h80, 48, 1'b0, 8'h00);
    check("slow_idle_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning TX FIFO entries; legal values are powers of two and at least 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port clk_en  input  1  16x-baud tick, one clk cycle wide.
REQ-005 SHALL have port wr_en  input  1  write strobe that pushes data_in into the FIFO.
REQ-006 SHALL have port data_in  input  8  byte to transmit, sampled when wr_en=1.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port tx  output  1  registered serial line, idle high.
REQ-009 SHALL have port busy  output  1  state machine not in IDLE.
REQ-010 SHALL have port tx_done  output  1  one-clk pulse at the end of each stop bit.

Function
REQ-011 SHALL implement the FIFO with a write pointer, a read pointer and a count; pointers wrap modulo DEPTH.
REQ-012 SHALL accept a write only when full=0 at the start of the cycle; a write while full is dropped with no pointer or count change.
REQ-013 SHALL treat a push and a pop in the same cycle as count unchanged; full and empty are evaluated from the pre-cycle count.
REQ-014 SHALL have states IDLE, START, DATA, PARITY (macro builds only) and STOP.
REQ-015 IDLE: on a clk_en cycle with the FIFO non-empty, SHALL pop the head into the shift register, drive tx=0, clear the tick counter and the bit index, and enter START.
REQ-016 SHALL hold every bit for exactly 16 clk_en ticks; the 4-bit tick counter advances only on clk_en, and on the tick where it equals 15 the FSM moves to the next bit and the counter returns to 0.
REQ-017 DATA: SHALL send 8 bits LSB first, with a 3-bit index; after index 7 the FSM goes to PARITY (macro builds) or STOP.
REQ-018 STOP: SHALL drive tx=1; on the final tick it SHALL pulse tx_done for one clk.
REQ-019 On that same final STOP tick, if the FIFO is non-empty the FSM SHALL pop and enter START directly with no idle gap; otherwise it SHALL enter IDLE.
REQ-020 SHALL leave tx and the FSM unchanged on cycles where clk_en=0, including writes; there is no timeout.
REQ-021 SHALL give busy=1 in every state except IDLE.
REQ-022 SHALL not pop in IDLE a byte written in the same cycle, since the FIFO is empty pre-cycle; that byte is popped on the next clk_en.

Reset
REQ-023 SHALL on rst=1 immediately force tx=1, busy=0, full=0 and tx_done=0, set state to IDLE, and clear the pointers, count and counters.
REQ-024 SHALL, on reset mid-frame, abort the frame, discard the FIFO contents and emit no tx_done.
REQ-025 SHALL resume normal operation on the first clk after rst deasserts.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, SHALL insert a PARITY state between DATA and STOP that sends an even-parity bit (XOR of the 8 data bits) for 16 ticks; frame length is 11 bits.
REQ-027 Without UART_TX_PARITY_EN, SHALL not build a PARITY state; DATA goes directly to STOP and frame length is 10 bits.

Verification
REQ-028 Scenario: clk_en every cycle, write 0x55 -> tx sends 0, then 1,0,1,0,1,0,1,0, then 1, each held for 16 clks; tx_done rises 160 clks after the first tick (176 with parity, parity bit 0).
REQ-029 Scenario: clk_en held 0, write 0x01..0x04 -> full=1 after the 4th write; a 5th write of 0xFF is dropped; with clk_en enabled, 4 contiguous frames follow with no idle-high gap, 4 tx_done pulses, and no 0xFF frame.
REQ-030 Scenario (UART_TX_PARITY_EN): write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; then stop bit 1.
REQ-031 Scenario: assert rst during DATA bit 3 of 0xA5 -> tx=1 and busy=0 in the same cycle with no tx_done; after release, writing 0x3C yields one correct frame.
REQ-032 Scenario: clk_en every 3rd clk, write 0x80 -> each bit lasts 48 clks, and tx is 1 only during bit 7 and the stop bit.
REQ-033 Scenario: wr_en in the same cycle as the final STOP tick while full -> write dropped and count goes DEPTH-1; while not full -> count unchanged.
